data_plane_tx_arbiter: RTL and testbench

//  Shares the node's single data-plane TX channel between NUM_REQ local requesters (GPP, DMA, ...).

---
 rtl/data_plane_tx_arbiter_pkg.sv | 10 +
 rtl/data_plane_tx_arbiter_rr_arbiter.sv | 19 +
 rtl/data_plane_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_data_plane_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_plane_tx_arbiter_pkg.sv
// dp_pkg: data-plane packet format, idle marker and TX arbiter state encoding
package dp_pkg;
  localparam logic [15:0] IDLE_ID    = 16'hFFFF;
  localparam int          DP_PKT_LEN = 5;
  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] data;
  } dp_packet_t;
  typedef enum logic [1:0] {DP_TX_IDLE, DP_TX_SEND, DP_TX_WAIT_ACK} dp_tx_state_t;
endpackage

// File: rtl/data_plane_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the last grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[IW'((int'(last) + i) % N)]) idx = IW'((int'(last) + i) % N);
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/data_plane_tx_arbiter.sv
// data_plane_tx_arbiter: round-robin owner of the data-plane TX channel; streams PKT_LEN-word bursts, holds until rx ack.
// Define DP_TX_ACK_TIMEOUT_EN to abandon a burst after ACK_TIMEOUT unacknowledged WAIT_ACK cycles.
module data_plane_tx_arbiter
  import dp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PKT_LEN     = DP_PKT_LEN,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           node_id,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] req_dest_id,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic [31:0]           data_tx_packet,
  input  logic                  tx_complete_ack,
  output logic [NUM_REQ-1:0]    tx_done,
  output logic                  tx_error
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  dp_tx_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, tx_done_q, tx_done_d, arb_gnt;
  logic [IW-1:0]      gidx_q, gidx_d, rr_q, rr_d, arb_idx;
  logic [15:0]        dest_q, dest_d, arb_dest, cur_data;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      to_q, to_d;
  dp_packet_t         pkt_q, pkt_d;
  logic               tx_error_q, tx_error_d, arb_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .last(rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign arb_dest = req_dest_id[{arb_idx, 4'b0} +: 16];
  assign cur_data = req_data[{gidx_q, 4'b0} +: 16];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    to_d       = '0;
    tx_done_d  = '0;
    tx_error_d = 1'b0;
    pkt_d      = (state_q == DP_TX_SEND) ? {dest_q, cur_data} : {IDLE_ID, 16'h0};
    case (state_q)
      DP_TX_IDLE: if (arb_any) begin
        dest_d = arb_dest;
        // a burst to ourselves would never be acknowledged, so reject it up front
        if (arb_dest == node_id) begin
          tx_error_d = 1'b1;
          rr_d       = arb_idx;
        end else begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          cnt_d   = '0;
          state_d = DP_TX_SEND;
        end
      end
      DP_TX_SEND: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(PKT_LEN - 1)) ? DP_TX_WAIT_ACK : DP_TX_SEND;
      end
      DP_TX_WAIT_ACK: begin
        to_d = to_q + TW'(1);
        if (tx_complete_ack) begin
          tx_done_d = grant_q;
          rr_d      = gidx_q;
          grant_d   = '0;
          state_d   = DP_TX_IDLE;
        end
`ifdef DP_TX_ACK_TIMEOUT_EN
        else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          tx_error_d = 1'b1;
          rr_d       = gidx_q;
          grant_d    = '0;
          state_d    = DP_TX_IDLE;
        end
`endif
      end
      default: state_d = DP_TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DP_TX_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= IW'(NUM_REQ - 1);
      dest_q     <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      tx_done_q  <= '0;
      tx_error_q <= 1'b0;
      pkt_q      <= {IDLE_ID, 16'h0};
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
      pkt_q      <= pkt_d;
    end
  end

  assign req_ready      = (state_q == DP_TX_SEND) ? grant_q : '0;
  assign grant          = grant_q;
  assign data_tx_packet = pkt_q;
  assign tx_done        = tx_done_q;
  assign tx_error       = tx_error_q;
endmodule

// File: tb/tb_data_plane_tx_arbiter.sv
// tb_data_plane_tx_arbiter: directed bursts checked every cycle against a transaction-level channel-owner model
module tb_data_plane_tx_arbiter;
  localparam int N  = 4;
  localparam int L  = 5;
  localparam int TO = 64;
  localparam logic [31:0] IDLE_PKT = 32'hFFFF_0000;

  logic clk = 1'b0, rst = 1'b1, ack = 1'b0;
  logic [15:0] node_id = 16'h0001;
  logic [N-1:0] req = '0;
  logic [N*16-1:0] req_dest_id, req_data;
  logic [N-1:0] req_ready, grant, tx_done, rdy_s;
  logic tx_error;
  logic [31:0] pkt;
  logic [15:0] dest_a[N], base_a[N];
  int widx[N] = '{default: 0};
  int n_chk = 0, n_fail = 0;

  int m_owner, m_sent, m_wait, m_last, run_len = 0;
  logic [15:0] m_dest;
  logic [31:0] m_pkt;
  logic [N-1:0] m_done;
  logic m_err;
  bit m_ok = 0;

  data_plane_tx_arbiter dut (
    .clk(clk), .rst(rst), .node_id(node_id), .req(req), .req_dest_id(req_dest_id),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .data_tx_packet(pkt),
    .tx_complete_ack(ack), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_dest_id[16*i +: 16] = dest_a[i];
      req_data[16*i +: 16]    = base_a[i] + 16'(widx[i]);
    end
  end

  // requesters: advance after a consumed word, rewind when idle
  always @(negedge clk) rdy_s = req_ready;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (rdy_s[i]) widx[i]++;
      else if (!req[i]) widx[i] = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int pick = -1;
    m_done = '0;
    m_err  = 1'b0;
    m_pkt  = IDLE_PKT;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_sent = 0; m_wait = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int j = 1; j <= N; j++)
        if (pick < 0 && req[(m_last + j) % N]) pick = (m_last + j) % N;
      if (pick >= 0) begin
        if (dest_a[pick] == node_id) begin
          m_err = 1'b1; m_last = pick;
        end else begin
          m_owner = pick; m_dest = dest_a[pick]; m_sent = 0; m_wait = 0;
        end
      end
    end else if (m_sent < L) begin
      m_pkt = {m_dest, base_a[m_owner] + 16'(widx[m_owner])};
      m_sent++;
    end else if (ack) begin
      m_done[m_owner] = 1'b1; m_last = m_owner; m_owner = -1;
    end else begin
      m_wait++;
`ifdef DP_TX_ACK_TIMEOUT_EN
      if (m_wait == TO) begin
        m_err = 1'b1; m_last = m_owner; m_owner = -1;
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("grant", grant, m_owner >= 0 ? (1 << m_owner) : 0);
      chk("req_ready", req_ready, (m_owner >= 0 && m_sent < L) ? (1 << m_owner) : 0);
      chk("packet", pkt, m_pkt);
      chk("tx_done", tx_done, m_done);
      chk("tx_error", tx_error, m_err);
    end
    if (pkt !== IDLE_PKT) run_len++;
    else if (run_len > 0) begin
      chk("burst_len", run_len, L);
      run_len = 0;
    end
    if (rst) run_len = 0;
    model_step();
    m_ok = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack_state();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (grant != 0 && req_ready == 0) ok = 1;
    end
    chk("reach_wait_ack", ok, 1);
  endtask

  task automatic serve(input int gap, input bit drop, output int who);
    wait_ack_state();
    repeat (gap) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    who = -1;
    for (int i = 0; i < N; i++) if (tx_done[i]) who = i;
    if (drop && who >= 0) req[who] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int who, cnt;
    int order[5];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    dest_a = '{16'h0003, 16'h0005, 16'h0007, 16'h0009};
    base_a = '{16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0};
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_packet", pkt, 32'hFFFF_0000);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);

    req[0] = 1'b1;
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_pre_idle", pkt, 32'hFFFF_0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_word", pkt, 32'h0003_00A0 + k);
    end
    tick();
    chk("t1_idle_after", pkt, 32'hFFFF_0000);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req[0] = 1'b0;
    chk("t1_done", tx_done, 4'b0001);
    tick();
    chk("t1_done_pulse", tx_done, 4'b0000);

    do_reset();
    req = '1;
    for (int b = 0; b < 5; b++) begin
      serve(3, 0, who);
      order[b] = who;
    end
    req = '0;
    for (int b = 0; b < 5; b++) chk("t2_order", order[b], exp_o[b]);
    tick();
    chk("t2_released", grant, 0);

    do_reset();
    dest_a[2] = 16'h0001;
    req[2] = 1'b1;
    tick();
    chk("t3_error", tx_error, 1);
    chk("t3_grant", grant, 0);
    req[2] = 1'b0;
    dest_a[2] = 16'h0007;
    req[1] = 1'b1;
    req[3] = 1'b1;
    tick();
    chk("t3_next_grant", grant, 4'b1000);
    chk("t3_error_pulse", tx_error, 0);
    serve(1, 1, who);
    chk("t3_first", who, 3);
    serve(1, 1, who);
    chk("t3_second", who, 1);

    do_reset();
    req[1] = 1'b1;
    repeat (4) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_no_done", tx_done, 0);
    repeat (5) tick();
    chk("t4_still_waiting", grant, 4'b0010);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_done", tx_done, 4'b0010);
    req[1] = 1'b0;

    do_reset();
    req[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    req[0] = 1'b0;
    tick();
    chk("t5_grant", grant, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_packet", pkt, 32'hFFFF_0000);
    rst = 1'b0;
    req[1] = 1'b1;
    tick();
    chk("t5_new_grant", grant, 4'b0010);
    tick();
    chk("t5_first_word", pkt, 32'h0005_00B0);
    serve(0, 1, who);
    chk("t5_done", who, 1);

`ifdef DP_TX_ACK_TIMEOUT_EN
    do_reset();
    req[3] = 1'b1;
    wait_ack_state();
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!tx_error && cnt < 100);
    req[3] = 1'b0;
    chk("t6_timeout_cycles", cnt, TO);
    chk("t6_no_done", tx_done, 0);
    tick();
    req[3] = 1'b1;
    wait_ack_state();
    repeat (TO - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req[3] = 1'b0;
    chk("t6_ack_wins_done", tx_done, 4'b1000);
    chk("t6_ack_wins_error", tx_error, 0);
`else
    cnt = 0;
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
